// File: rtl/rf_dbg_pkg.sv
// Shared types and constants for the register-file debug access controller.
// The request struct uses the default widths; wider builds declare their own.
package rf_dbg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int unsigned X0_ADDR = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HALT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dbg_state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } dbg_req_t;

endpackage

// File: rtl/rf_dbg_mux.sv
// Regfile port mux: core owns the write and rs1-read ports except during the
// single ACCESS cycle, when the latched debug request drives them.
module rf_dbg_mux
    import rf_dbg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  dbg_state_e        i_state,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    input  logic              i_core_rd_wren,
    input  logic [ADDR_W-1:0] i_core_rd_addr,
    input  logic [DATA_W-1:0] i_core_rd_data,
    input  logic [ADDR_W-1:0] i_core_rs1_addr,
    output logic              o_rf_rd_wren,
    output logic [ADDR_W-1:0] o_rf_rd_addr,
    output logic [DATA_W-1:0] o_rf_rd_data,
    output logic [ADDR_W-1:0] o_rf_rs1_addr
);

    logic dbg_sel;
    logic dbg_x0;

    assign dbg_sel = (i_state == ST_ACCESS);
    assign dbg_x0  = (i_dbg_addr == ADDR_W'(X0_ADDR));

    always_comb begin
        o_rf_rd_wren  = i_core_rd_wren;
        o_rf_rd_addr  = i_core_rd_addr;
        o_rf_rd_data  = i_core_rd_data;
        o_rf_rs1_addr = i_core_rs1_addr;
        if (dbg_sel) begin
            // Core writes in this cycle are dropped; x0 is never written.
            o_rf_rd_wren  = i_dbg_we && !dbg_x0;
            o_rf_rd_addr  = i_dbg_addr;
            o_rf_rd_data  = i_dbg_wdata;
            o_rf_rs1_addr = i_dbg_addr;
        end
    end

endmodule

// File: rtl/rf_dbg_access.sv
// Debug initiator access to the RV32 register file: halts the core, performs
// one read or write in a single ACCESS cycle, then returns a response.
module rf_dbg_access
    import rf_dbg_pkg::*;
#(
    parameter int HALT_TIMEOUT = 16,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_halt_req,
    input  logic              i_core_halted,
    input  logic              i_core_rd_wren,
    input  logic [ADDR_W-1:0] i_core_rd_addr,
    input  logic [DATA_W-1:0] i_core_rd_data,
    input  logic [ADDR_W-1:0] i_core_rs1_addr,
    output logic              o_rf_rd_wren,
    output logic [ADDR_W-1:0] o_rf_rd_addr,
    output logic [DATA_W-1:0] o_rf_rd_data,
    output logic [ADDR_W-1:0] o_rf_rs1_addr,
    input  logic [DATA_W-1:0] i_rf_rs1_data,
    output dbg_state_e        o_dbg_state
);

    localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);
    // The first HALT cycle is the one in which halt_req first reaches the
    // core, so the error response lands HALT_TIMEOUT+1 cycles after accept.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    dbg_state_e       state;
    req_t             req_q;
    logic [CNT_W-1:0] cnt;
    logic             req_x0;

    assign req_x0      = (req_q.addr == ADDR_W'(X0_ADDR));
    assign o_dbg_state = state;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid and its payload hold until then, ready may be anything.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            cnt         <= '0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_halt_req  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        req_q       <= '{we: i_req_we, addr: i_req_addr, wdata: i_req_wdata};
                        cnt         <= '0;
                        o_req_ready <= 1'b0;
                        o_halt_req  <= 1'b1;
                        state       <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (i_core_halted) begin
                        state <= ST_ACCESS;
                    end else if (cnt == CNT_LAST) begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= '0;
                        o_rsp_err   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ACCESS: begin
                    o_rsp_valid <= 1'b1;
                    if (req_q.we) begin
                        o_rsp_rdata <= '0;
                        o_rsp_err   <= req_x0;
                    end else begin
                        o_rsp_rdata <= req_x0 ? '0 : i_rf_rs1_data;
                        o_rsp_err   <= 1'b0;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        o_halt_req  <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    rf_dbg_mux #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mux (
        .i_state        (state),
        .i_dbg_we       (req_q.we),
        .i_dbg_addr     (req_q.addr),
        .i_dbg_wdata    (req_q.wdata),
        .i_core_rd_wren (i_core_rd_wren),
        .i_core_rd_addr (i_core_rd_addr),
        .i_core_rd_data (i_core_rd_data),
        .i_core_rs1_addr(i_core_rs1_addr),
        .o_rf_rd_wren   (o_rf_rd_wren),
        .o_rf_rd_addr   (o_rf_rd_addr),
        .o_rf_rd_data   (o_rf_rd_data),
        .o_rf_rs1_addr  (o_rf_rs1_addr)
    );

endmodule
